// File: rtl/hcsr04_ranger.sv
// ---------------------------------------------------------------------------
// hcsr04_ranger
//
// Ultrasonic ranging front end for the HC-SR04 sensor. It issues the trigger
// pulse, synchronises the echo, times the echo width in microseconds and
// publishes a registered result with a one-clock valid strobe. If the echo
// never rises, or stays high too long, the result is a timeout (16'hFFFF).
//
// Ports:
//   clk_clk        in   1   system clock
//   reset_reset    in   1   synchronous reset, active-high
//   enable         in   1   1 = free-running periodic ranging
//   hcecho_export  in   1   raw echo from the sensor (asynchronous)
//   near_thresh    in  16   near threshold in microseconds
//   hctrig_export  out  1   trigger to the sensor, registered
//   dist_us        out 16   last echo width in us, 16'hFFFF on timeout
//   dist_valid     out  1   one-clock strobe when a new result is published
//   timeout        out  1   last measurement timed out
//   near           out  1   last measurement valid and below near_thresh
//   busy           out  1   a measurement cycle is in progress
// ---------------------------------------------------------------------------
module hcsr04_ranger #(
  parameter int CLK_HZ     = 50000000,
  parameter int TRIG_US    = 10,
  parameter int GAP_US     = 60000,
  parameter int TIMEOUT_US = 30000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic        hcecho_export,
  input  logic [15:0] near_thresh,
  output logic        hctrig_export,
  output logic [15:0] dist_us,
  output logic        dist_valid,
  output logic        timeout,
  output logic        near,
  output logic        busy
);

  localparam int DIV = CLK_HZ / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW  = (GAP_US > 1) ? $clog2(GAP_US + 1) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_US);
  localparam logic [GW-1:0] GAP_ARM   = GW'(GAP_US - 1);
  localparam logic [15:0]   TRIG_LAST = 16'(TRIG_US - 1);
  localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_US - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic          us_tick;
  logic          echo_meta;
  logic          echo_s;
  logic [15:0]   cnt;
  logic [GW-1:0] gap_cnt;
  logic          finish_now;
  logic          finish_to;

  // Free-running microsecond prescaler; the FSM never touches it, so tick
  // phase is independent of when a measurement starts. With DIV = 1 the
  // counter stays at 0 and every clock is a tick.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc <= '0;
    end else if (presc == PRE_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign us_tick = (presc == PRE_LAST);

  // Two-flop synchroniser for the asynchronous echo pin. The FSM works on
  // the level of echo_s, so an echo already high when WAIT_RISE is entered
  // counts as a rise.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      echo_meta <= 1'b0;
      echo_s    <= 1'b0;
    end else begin
      echo_meta <= hcecho_export;
      echo_s    <= echo_meta;
    end
  end

  // End-of-measurement detection. The timeout test comes first in MEASURE so
  // an echo falling on the very tick the limit is reached still reports a
  // timeout. cnt reaching TIMEOUT_US is detected one count early (on the
  // tick that would make it TIMEOUT_US) so cnt never needs to hold the limit.
  always_comb begin
    finish_now = 1'b0;
    finish_to  = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (!echo_s && us_tick && (cnt == TO_LAST)) begin
          finish_now = 1'b1;
          finish_to  = 1'b1;
        end
      end
      MEASURE: begin
        if (us_tick && (cnt == TO_LAST)) begin
          finish_now = 1'b1;
          finish_to  = 1'b1;
        end else if (!echo_s) begin
          finish_now = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Main sequencer. All outputs are registered here. The finish edge
  // publishes the result, pulses dist_valid and returns straight to IDLE
  // with the gap counter cleared, so the inter-measurement gap always starts
  // from the moment the result is published.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      cnt           <= '0;
      gap_cnt       <= '0;
      hctrig_export <= 1'b0;
      dist_us       <= '0;
      dist_valid    <= 1'b0;
      timeout       <= 1'b0;
      near          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      if (finish_now) begin
        dist_us    <= finish_to ? 16'hFFFF : cnt;
        timeout    <= finish_to;
        near       <= !finish_to && (cnt < near_thresh);
        dist_valid <= 1'b1;
        gap_cnt    <= '0;
        cnt        <= '0;
        busy       <= 1'b0;
        state      <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // The gap keeps counting (and saturating) even while disabled,
            // so enabling after a long pause triggers on the next tick.
            if (us_tick && (gap_cnt < GAP_MAX)) begin
              gap_cnt <= gap_cnt + GW'(1);
            end
            if (enable && us_tick && (gap_cnt >= GAP_ARM)) begin
              state         <= TRIG;
              cnt           <= '0;
              hctrig_export <= 1'b1;
              busy          <= 1'b1;
            end
          end
          TRIG: begin
            // Entered on a tick edge, so TRIG_US further ticks give exactly
            // TRIG_US*DIV clocks of trigger.
            if (us_tick) begin
              if (cnt == TRIG_LAST) begin
                hctrig_export <= 1'b0;
                cnt           <= '0;
                state         <= WAIT_RISE;
              end else begin
                cnt <= cnt + 16'd1;
              end
            end
          end
          WAIT_RISE: begin
            if (echo_s) begin
              cnt   <= '0;
              state <= MEASURE;
            end else if (us_tick) begin
              cnt <= cnt + 16'd1;
            end
          end
          MEASURE: begin
            // Reaching here without finishing means echo_s is still high.
            if (us_tick) begin
              cnt <= cnt + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hcsr04_ranger.md
Name: hcsr04_ranger

Overview:
- Ultrasonic ranging front end for the HC-SR04 sensor. Sits directly upstream of the Nios system's hctrig/hcecho PIO pair.
- Generates the trigger pulse, synchronises and times the echo pulse in microseconds, and handles missing or stuck echoes with a timeout.
- Presents a registered distance word with a one-cycle valid strobe, plus a "near" flag for buzzer/motor interlocks, so software reads a finished value instead of bit-banging the pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency; DIV = CLK_HZ/1000000 clocks per microsecond tick (DIV >= 1, integer).
- TRIG_US, 10, trigger pulse width in us.
- GAP_US, 60000, idle us between end of one measurement and next trigger.
- TIMEOUT_US, 30000, maximum us waiting for echo rise and maximum echo width (< 65535).

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous reset, active-high
- enable  in  1  1 = free-running periodic ranging
- hcecho_export  in  1  raw echo from sensor (asynchronous)
- near_thresh  in  16  near threshold in us
- hctrig_export  out  1  trigger to sensor, registered
- dist_us  out  16  last echo width in us; 16'hFFFF on timeout
- dist_valid  out  1  one-cycle strobe, dist_us/timeout just updated
- timeout  out  1  last measurement timed out
- near  out  1  last measurement valid and dist_us < near_thresh
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous, active-high): all outputs 0; prescaler, gap, width and wait counters 0; sync flops 0; FSM = IDLE. Reset mid-operation aborts immediately: hctrig drops on the next edge, no dist_valid is issued, and the gap restarts from 0.
- Prescaler: counts 0..DIV-1 and asserts us_tick for one clock at DIV-1. It is free-running and unaffected by the FSM. If DIV = 1, us_tick is asserted every clock.
- Echo: 2-flop synchroniser gives echo_s. Level-sensitive; no edge detector.
- IDLE: gap_cnt increments on us_tick and saturates at GAP_US. When enable = 1, us_tick = 1 and gap_cnt >= GAP_US-1, go to TRIG and clear cnt. With enable = 0 the FSM stays in IDLE, and gap_cnt keeps counting and saturating.
- TRIG: hctrig_export = 1 for exactly TRIG_US ticks (TRIG_US*DIV clocks). Then hctrig = 0, go to WAIT_RISE, clear cnt.
- WAIT_RISE:
  - echo_s = 1 → go to MEASURE with cnt = 0.
  - Otherwise cnt increments on us_tick. If cnt reaches TIMEOUT_US → FINISH with timeout.
  - An echo_s already high on entry is accepted as a rise.
- MEASURE:
  - cnt increments on us_tick while echo_s = 1.
  - echo_s = 0 → FINISH with result cnt.
  - cnt reaches TIMEOUT_US → FINISH with timeout.
- FINISH (transition edge, no extra state), on the same edge:
  - dist_us <= cnt, or 16'hFFFF on timeout.
  - timeout <= timeout condition.
  - near <= (!timeout_cond && cnt < near_thresh).
  - dist_valid <= 1 for exactly one clock.
  - FSM → IDLE and gap_cnt <= 0.
- Held outputs: dist_us, timeout and near hold until the next FINISH. enable falling mid-measurement does not abort; the current measurement completes.
- Latency:
  - Echo pin edge → echo_s is 2 clocks.
  - echo_s fall → dist_valid is 1 clock.
  - Resolution is 1 us; the measured value is within ±1 of the true width in us.
- Simultaneous events: if echo_s falls on the same clock that cnt reaches TIMEOUT_US, the timeout wins.
- busy = (state != IDLE), registered.

Test Plan:
- CLK_HZ=2000000 (DIV=2), GAP_US=100, TRIG_US=10, enable=1 after reset → first hctrig rise ~200 clocks after reset; high for exactly 20 clocks; busy=1 from the trigger onward.
- Echo high 580 us, 5 us after trigger end → dist_us in 579..581, dist_valid high exactly 1 clock, 2–3 clocks after the echo fall; timeout=0.
- No echo, TIMEOUT_US=300 → dist_valid after 300 us in WAIT_RISE; dist_us=16'hFFFF, timeout=1, near=0; next trigger follows after a GAP_US gap.
- Echo stuck high, TIMEOUT_US=300 → FINISH at 300 us in MEASURE; timeout=1, dist_us=16'hFFFF.
- near_thresh=600: echo 580 us → near=1; next echo 1000 us → near=0; near_thresh=0 → near always 0.
- Reset asserted mid-MEASURE (echo still high) → next edge: hctrig=0, busy=0, dist_us=0, no dist_valid. enable=0 after reset → hctrig stays 0 for 10×GAP_US.
